// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, load-size encodings and the link register.
package cpu_pkg;

    localparam int JAL_OP   = 3;
    localparam int LINK_REG = 31;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

endpackage

// File: rtl/load_extract.sv
// Little-endian byte/half/word lane extraction with sign or zero extension,
// plus alignment check on the effective address.
module load_extract import cpu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misalign
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic        fill;

    assign b = raw[{addr_lo, 3'b000} +: 8];
    assign h = addr_lo[1] ? raw[31:16] : raw[15:0];
    assign w = raw[31:0];

    // Fill the whole word with the extension bit, then overlay the lane.
    always_comb begin
        fill     = 1'b0;
        data     = '0;
        misalign = 1'b0;
        case (ld_size)
            LD_BYTE: begin
                fill      = ~ld_unsigned & b[7];
                data      = {XLEN{fill}};
                data[7:0] = b;
            end
            LD_HALF: begin
                fill       = ~ld_unsigned & h[15];
                data       = {XLEN{fill}};
                data[15:0] = h;
                misalign   = addr_lo[0];
            end
            default: begin
                fill       = ~ld_unsigned & w[31];
                data       = {XLEN{fill}};
                data[31:0] = w;
                misalign   = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register: write-back select, load extraction, misalign
// qualification, stall/flush control and saturating retire/bubble counters.
module memwb_pipe_reg import cpu_pkg::*; #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int OP_W     = 6,
    parameter int LINK_REG = cpu_pkg::LINK_REG,
    parameter int JAL_OP   = cpu_pkg::JAL_OP,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  in_opcode,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [RA_W-1:0]  in_rd_addr,
    input  logic [XLEN-1:0]  in_alu_res,
    input  logic [XLEN-1:0]  in_mem_data,
    input  logic [XLEN-1:0]  in_hilo,
    input  logic             in_hi_sel,
    input  logic             in_lo_sel,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic             in_jump,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_unsigned,
    input  logic [1:0]       in_addr_lo,
    output logic             out_valid,
    output logic [OP_W-1:0]  out_opcode,
    output logic [XLEN-1:0]  out_pc,
    output logic [RA_W-1:0]  out_rd_addr,
    output logic [XLEN-1:0]  out_wdata,
    output logic             out_reg_write,
    output logic             out_jump,
    output logic             out_misalign,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic            is_jal;
    logic [XLEN-1:0] wdata_d;
    logic [RA_W-1:0] rd_d;
    logic            mis_d;
    logic            wen_d;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .raw         (in_mem_data),
        .ld_size     (in_ld_size),
        .ld_unsigned (in_ld_unsigned),
        .addr_lo     (in_addr_lo),
        .data        (ld_data),
        .misalign    (ld_mis)
    );

    assign is_jal = (in_opcode == OP_W'(JAL_OP));

    always_comb begin
        wdata_d = in_alu_res;
        rd_d    = in_rd_addr;
        if (is_jal) begin
            wdata_d = in_pc + XLEN'(4);
            rd_d    = RA_W'(LINK_REG);
        end else if (in_hi_sel || in_lo_sel) begin
            wdata_d = in_hilo;
        end else if (in_mem_to_reg) begin
            wdata_d = ld_data;
        end
        mis_d = in_valid & in_mem_to_reg & ld_mis;
        wen_d = in_valid & in_reg_write & ~mis_d & (rd_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_opcode    <= '0;
            out_pc        <= '0;
            out_rd_addr   <= '0;
            out_wdata     <= '0;
            out_reg_write <= 1'b0;
            out_jump      <= 1'b0;
            out_misalign  <= 1'b0;
            retired_cnt   <= '0;
            bubble_cnt    <= '0;
        end else if (flush) begin
            // Data fields keep their old values; only the control bits drop.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_jump      <= 1'b0;
            out_misalign  <= 1'b0;
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
        end else if (!stall) begin
            out_valid     <= in_valid;
            out_opcode    <= in_opcode;
            out_pc        <= in_pc;
            out_rd_addr   <= rd_d;
            out_wdata     <= wdata_d;
            out_reg_write <= wen_d;
            out_jump      <= in_valid & in_jump;
            out_misalign  <= mis_d;
            if (in_valid) begin
                if (retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
            end else begin
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memwb_pipe_reg.sv
// Directed bench for memwb_pipe_reg with hand-computed expectations; the
// counters are 4 bits wide so saturation is reachable in a few cycles.
module tb_memwb_pipe_reg;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int OP_W  = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, stall, flush, in_valid;
    logic [OP_W-1:0]  in_opcode;
    logic [XLEN-1:0]  in_pc, in_alu_res, in_mem_data, in_hilo;
    logic [RA_W-1:0]  in_rd_addr;
    logic             in_hi_sel, in_lo_sel, in_reg_write, in_mem_to_reg, in_jump;
    logic [1:0]       in_ld_size, in_addr_lo;
    logic             in_ld_unsigned;
    logic             out_valid, out_reg_write, out_jump, out_misalign;
    logic [OP_W-1:0]  out_opcode;
    logic [XLEN-1:0]  out_pc, out_wdata;
    logic [RA_W-1:0]  out_rd_addr;
    logic [CNT_W-1:0] retired_cnt, bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memwb_pipe_reg #(.XLEN(XLEN), .RA_W(RA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_pc(in_pc),
        .in_rd_addr(in_rd_addr), .in_alu_res(in_alu_res), .in_mem_data(in_mem_data),
        .in_hilo(in_hilo), .in_hi_sel(in_hi_sel), .in_lo_sel(in_lo_sel),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_jump(in_jump),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned), .in_addr_lo(in_addr_lo),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_wdata(out_wdata), .out_reg_write(out_reg_write),
        .out_jump(out_jump), .out_misalign(out_misalign),
        .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change only here, 1 time unit after the edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 0; in_opcode = '0; in_pc = '0; in_rd_addr = '0; in_alu_res = '0;
        in_mem_data = '0; in_hilo = '0; in_hi_sel = 0; in_lo_sel = 0; in_reg_write = 0;
        in_mem_to_reg = 0; in_jump = 0; in_ld_size = 2'd0; in_ld_unsigned = 0; in_addr_lo = 2'd0;
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [1:0] lo);
        clear_in();
        in_valid = 1; in_opcode = 6'd35; in_rd_addr = 5'd8; in_reg_write = 1;
        in_mem_to_reg = 1; in_mem_data = 32'h8899AABB;
        in_ld_size = sz; in_ld_unsigned = uns; in_addr_lo = lo;
        tick();
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        clear_in();
        tick();
        rst = 0;

        // Populate outputs so the reset check is meaningful
        in_valid = 1; in_opcode = 6'd5; in_pc = 32'h200; in_rd_addr = 5'd7;
        in_alu_res = 32'h55; in_reg_write = 1; in_jump = 1;
        tick();
        chk("pre_valid", out_valid, 1);
        chk("pre_wdata", out_wdata, 32'h55);
        chk("pre_jump", out_jump, 1);
        chk("pre_retired", retired_cnt, 1);

        rst = 1; stall = 1;
        tick();
        rst = 0; stall = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_opcode", out_opcode, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_rd", out_rd_addr, 0);
        chk("rst_wdata", out_wdata, 0);
        chk("rst_wen", out_reg_write, 0);
        chk("rst_jump", out_jump, 0);
        chk("rst_retired", retired_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);

        // JAL overrides mem_to_reg and the destination
        clear_in();
        in_valid = 1; in_opcode = 6'd3; in_pc = 32'h100; in_rd_addr = 5'd5;
        in_mem_to_reg = 1; in_reg_write = 1; in_jump = 1; in_alu_res = 32'h77;
        tick();
        chk("jal_wdata", out_wdata, 32'h104);
        chk("jal_rd", out_rd_addr, 31);
        chk("jal_wen", out_reg_write, 1);
        chk("jal_jump", out_jump, 1);
        chk("jal_retired", retired_cnt, 1);

        load(2'd0, 0, 2'd2);
        chk("lb2_wdata", out_wdata, 32'hFFFFFF99);
        chk("lb2_mis", out_misalign, 0);
        chk("lb2_wen", out_reg_write, 1);
        load(2'd1, 1, 2'd2);
        chk("lhu2_wdata", out_wdata, 32'h00008899);
        load(2'd1, 0, 2'd1);
        chk("lh1_mis", out_misalign, 1);
        chk("lh1_wen", out_reg_write, 0);
        chk("lh1_wdata", out_wdata, 32'hFFFFAABB);
        load(2'd0, 1, 2'd3);
        chk("lbu3_wdata", out_wdata, 32'h88);
        load(2'd3, 0, 2'd2);
        chk("lw2_mis", out_misalign, 1);
        chk("lw2_wen", out_reg_write, 0);
        load(2'd2, 0, 2'd0);
        chk("lw0_wdata", out_wdata, 32'h8899AABB);
        chk("lw0_mis", out_misalign, 0);
        chk("lw0_retired", retired_cnt, 7);

        // Stall holds everything even while inputs change
        clear_in();
        in_valid = 0; in_alu_res = 32'h1234; in_rd_addr = 5'd9;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_wdata", out_wdata, 32'h8899AABB);
            chk("stall_rd", out_rd_addr, 8);
            chk("stall_retired", retired_cnt, 7);
            chk("stall_bubble", bubble_cnt, 0);
        end
        flush = 1;
        tick();
        flush = 0; stall = 0;
        chk("flush_valid", out_valid, 0);
        chk("flush_wen", out_reg_write, 0);
        chk("flush_bubble", bubble_cnt, 1);
        chk("flush_retired", retired_cnt, 7);

        // MFHI to r0: value selected but write suppressed
        clear_in();
        in_valid = 1; in_hi_sel = 1; in_hilo = 32'hDEADBEEF; in_alu_res = 32'h1;
        in_rd_addr = 5'd0; in_reg_write = 1;
        tick();
        chk("mfhi_wdata", out_wdata, 32'hDEADBEEF);
        chk("mfhi_wen", out_reg_write, 0);
        in_hi_sel = 0; in_lo_sel = 1; in_rd_addr = 5'd3; in_hilo = 32'h0BADF00D;
        tick();
        chk("mflo_wdata", out_wdata, 32'h0BADF00D);
        chk("mflo_wen", out_reg_write, 1);
        chk("mflo_retired", retired_cnt, 9);

        clear_in();
        in_alu_res = 32'h42;
        tick();
        chk("bub_valid", out_valid, 0);
        chk("bub_bubble", bubble_cnt, 2);
        chk("alu_wdata", out_wdata, 32'h42);

        for (int i = 0; i < 20; i++) load(2'd2, 0, 2'd0);
        chk("sat_retired", retired_cnt, 15);
        chk("sat_bubble", bubble_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
